verilog_bm_154_233: RTL and testbench
=====================================

# verilog_bm_154_233

Single-character reciprocal substitution cipher ("modified Enigma") core. Each cycle it takes one 8-bit ASCII character and a 2-bit setting that selects one of four fixed involutive letter-pairing blocks, and registers the substituted character. Because every block is its own inverse, the same block decrypts: feeding ciphertext with the same setting sequence returns plaintext. The upstream controller rotates `setting` per character so that a repeated letter does not always encrypt to the same output.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in` input 8 (`[8:1]`): ASCII character to encrypt or decrypt.
- `setting` input 2: block select, 0–3.
- `out` output 8 (`[8:1]`): registered ASCII result.

## Operation
- Encoder: `"A"`–`"Z"` (0x41–0x5A) map to index 0–25 with case flag 0; `"a"`–`"z"` (0x61–0x7A) map to index 0–25 with case flag 1.
- Selected block maps the index to its partner.
- Decoder: converts the index back to ASCII with the original case.
- Any other byte passes through unchanged.
- Every block is an involution: the partner of the partner is the original letter. No letter maps to itself.
- Block 0 pairs: L-Y, O-A, B-C, D-E, F-G, H-I, J-K, M-N, P-Q, R-S, T-U, V-W, X-Z.
- Block 1 pairs: E-S, W-K, D-C, A-B, F-G, H-I, J-L, M-N, O-P, Q-R, T-U, V-X, Y-Z.
- Block 2 pairs: H-C, O-G, L-D, A-B, E-F, I-J, K-M, N-P, Q-R, S-T, U-V, W-X, Y-Z.
- Block 3 pairs: L-Q, R-H, A-B, C-D, E-F, G-I, J-K, M-N, O-P, S-T, U-V, W-X, Y-Z.
- Pairing is the same for upper and lower case. Example: setting 2 maps `"h"` to `"c"`.
- No internal rotor state. Rotation is entirely the caller's `setting` sequence.

## Timing
- Latency 1 cycle: `out` on edge n+1 equals f(`in`, `setting`) sampled at edge n.
- Throughput: one character per cycle. No handshake; every cycle is valid.
- Reset: `rst_n` low forces `out` = 8'h00 immediately, without waiting for a clock edge. `out` holds 8'h00 while `rst_n` is low.
- First edge after `rst_n` deasserts registers the current inputs normally.
- Reset asserted mid-stream discards the pending character.
- Changing `setting` and `in` in the same cycle is allowed: both are sampled together.
- No X-propagation requirement beyond pass-through of non-letters.

## Structure
- Shared package holds:
  - the ASCII range constants (`"A"`, `"Z"`, `"a"`, `"z"`);
  - the 5-bit letter index type;
  - the four 26-entry partner tables.
- One sub-module, `enigma_reflector`: combinational, maps (5-bit index, 2-bit setting) to a 5-bit partner.
- The top contains the encoder, decoder, pass-through mux and output register.

## Test plan
- Reset: assert `rst_n` = 0 with `in` = `"H"` → `out` = 8'h00 asynchronously. After release and one edge with `setting` = 2 → `out` = `"C"`.
- Encrypt `"HELLOWORLD"`, one character per cycle, with settings 2,1,0,3,2,1,0,3,2,1 → `out` stream `"CSYQGKAHDC"`, each character one cycle after its input.
- Decrypt `"CSYQGKAHDC"` with the same setting sequence → `"HELLOWORLD"`.
- Involution sweep: for all 4 settings × 26 letters, f(f(x)) = x and f(x) ≠ x. Repeat for lowercase and check case is preserved (setting 3, `"r"` → `"h"`).
- Pass-through: `" "`, `"0"`, 8'h00, 8'hFF, `"@"`, `"["` with any setting → unchanged.
- Back-to-back `"L"` with settings 0 then 3 → `"Y"` then `"Q"`, showing the same letter yields different ciphertext under rotation.

Source files
------------

// File: rtl/verilog_bm_154_233_pkg.sv
// Shared constants and partner tables for the reciprocal substitution cipher.
// Each table is an involution over letter indices 0 (A) .. 25 (Z).
package verilog_bm_154_233_pkg;

  typedef logic [8:1] ascii_t;
  typedef logic [4:0] idx_t;

  localparam ascii_t CH_UP_A = 8'h41;
  localparam ascii_t CH_UP_Z = 8'h5A;
  localparam ascii_t CH_LO_A = 8'h61;
  localparam ascii_t CH_LO_Z = 8'h7A;

  localparam int unsigned NUM_LETTERS = 26;

  localparam idx_t BLK0 [NUM_LETTERS] = '{
    5'd14, 5'd2,  5'd1,  5'd4,  5'd3,  5'd6,  5'd5,  5'd8,  5'd7,  5'd10,
    5'd9,  5'd24, 5'd13, 5'd12, 5'd0,  5'd16, 5'd15, 5'd18, 5'd17, 5'd20,
    5'd19, 5'd22, 5'd21, 5'd25, 5'd11, 5'd23
  };

  localparam idx_t BLK1 [NUM_LETTERS] = '{
    5'd1,  5'd0,  5'd3,  5'd2,  5'd18, 5'd6,  5'd5,  5'd8,  5'd7,  5'd11,
    5'd22, 5'd9,  5'd13, 5'd12, 5'd15, 5'd14, 5'd17, 5'd16, 5'd4,  5'd20,
    5'd19, 5'd23, 5'd10, 5'd21, 5'd25, 5'd24
  };

  localparam idx_t BLK2 [NUM_LETTERS] = '{
    5'd1,  5'd0,  5'd7,  5'd11, 5'd5,  5'd4,  5'd14, 5'd2,  5'd9,  5'd8,
    5'd12, 5'd3,  5'd10, 5'd15, 5'd6,  5'd13, 5'd17, 5'd16, 5'd19, 5'd18,
    5'd21, 5'd20, 5'd23, 5'd22, 5'd25, 5'd24
  };

  localparam idx_t BLK3 [NUM_LETTERS] = '{
    5'd1,  5'd0,  5'd3,  5'd2,  5'd5,  5'd4,  5'd8,  5'd17, 5'd6,  5'd10,
    5'd9,  5'd16, 5'd13, 5'd12, 5'd15, 5'd14, 5'd11, 5'd7,  5'd19, 5'd18,
    5'd21, 5'd20, 5'd23, 5'd22, 5'd25, 5'd24
  };

endpackage

// File: rtl/verilog_bm_154_233_if.sv
// Character stream bus: input character and block select in, substituted character out.
interface verilog_bm_154_233_if;
  import verilog_bm_154_233_pkg::*;

  ascii_t     in;
  logic [1:0] setting;
  ascii_t     out;

  modport master (output in, output setting, input out);
  modport slave  (input in, input setting, output out);
endinterface

// File: rtl/verilog_bm_154_233_enigma_reflector.sv
// Combinational reflector: letter index and block select to partner index.
module enigma_reflector
  import verilog_bm_154_233_pkg::*;
(
  input  idx_t       i_idx,
  input  logic [1:0] i_setting,
  output idx_t       o_partner
);

  always_comb begin
    o_partner = i_idx;
    // Indices above 25 only arise for non-letters, whose result is discarded.
    if (i_idx < 5'(NUM_LETTERS)) begin
      unique case (i_setting)
        2'd0: o_partner = BLK0[i_idx];
        2'd1: o_partner = BLK1[i_idx];
        2'd2: o_partner = BLK2[i_idx];
        2'd3: o_partner = BLK3[i_idx];
        default: o_partner = i_idx;
      endcase
    end
  end

endmodule

// File: rtl/verilog_bm_154_233.sv
// Reciprocal substitution cipher core: encode letter, reflect, decode with original case,
// pass non-letters through, register the result.
module verilog_bm_154_233
  import verilog_bm_154_233_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  verilog_bm_154_233_if.slave    bus
);

  logic   w_is_upper;
  logic   w_is_lower;
  ascii_t w_base;
  idx_t   w_idx;
  idx_t   w_partner;
  ascii_t w_next;
  ascii_t r_out;

  always_comb begin
    w_is_upper = (bus.in >= CH_UP_A) && (bus.in <= CH_UP_Z);
    w_is_lower = (bus.in >= CH_LO_A) && (bus.in <= CH_LO_Z);
    w_base     = w_is_lower ? CH_LO_A : CH_UP_A;
    w_idx      = 5'(bus.in - w_base);
  end

  enigma_reflector u_reflector (
    .i_idx     (w_idx),
    .i_setting (bus.setting),
    .o_partner (w_partner)
  );

  always_comb begin
    w_next = bus.in;
    if (w_is_upper || w_is_lower) begin
      w_next = w_base + {3'b000, w_partner};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign bus.out = r_out;

endmodule

// File: tb/tb_verilog_bm_154_233.sv
// Self-checking bench for the reciprocal substitution cipher core.
module tb_verilog_bm_154_233;

  logic clk;
  logic rst_n;

  verilog_bm_154_233_if bus ();

  verilog_bm_154_233 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Pairing lists: characters at positions 2k and 2k+1 are partners.
  string PAIRS [4] = '{
    "LYOABCDEFGHIJKMNPQRSTUVWXZ",
    "ESWKDCABFGHIJLMNOPQRTUVXYZ",
    "HCOGLDABEFIJKMNPQRSTUVWXYZ",
    "LQRHABCDEFGIJKMNOPSTUVWXYZ"
  };

  function automatic logic [7:0] model(input logic [7:0] c, input logic [1:0] s);
    logic       up;
    logic       lo;
    logic [7:0] u;
    logic [7:0] p;
    up = (c >= 8'h41) && (c <= 8'h5A);
    lo = (c >= 8'h61) && (c <= 8'h7A);
    if (!up && !lo) return c;
    u = lo ? c - 8'd32 : c;
    p = u;
    for (int unsigned i = 0; i < 26; i++) begin
      if (PAIRS[s][i] == u) p = PAIRS[s][i ^ 1];
    end
    return lo ? p + 8'd32 : p;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] exp_q;
  logic       have = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= 8'h00;
      have  <= 1'b1;
    end else begin
      exp_q <= model(bus.in, bus.setting);
    end
  end

  always @(negedge clk) begin
    if (have) begin
      compared++;
      if (bus.out !== exp_q) begin
        mismatched++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, bus.out, exp_q);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, expv);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [1:0] s);
    @(negedge clk);
    bus.in      = c;
    bus.setting = s;
    @(posedge clk);
    #1;
  endtask

  string      pt = "HELLOWORLD";
  string      ct = "CSYQGKAHDC";
  logic [1:0] seq [10] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
  logic [7:0] pass [6] = '{8'h20, 8'h30, 8'h00, 8'hFF, 8'h40, 8'h5B};

  initial begin
    logic [7:0] x;
    logic [7:0] y;
    rst_n       = 1'b1;
    bus.in      = 8'h48;
    bus.setting = 2'd2;
    #1 rst_n = 1'b0;
    #2 check("rst_async", bus.out, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_hold", bus.out, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_first", bus.out, 8'h43);

    for (int unsigned i = 0; i < 10; i++) begin
      drive(pt[i], seq[i]);
      check("encrypt", bus.out, ct[i]);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      drive(ct[i], seq[i]);
      check("decrypt", bus.out, pt[i]);
    end

    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned k = 0; k < 26; k++) begin
        for (int unsigned cs = 0; cs < 2; cs++) begin
          x = (cs == 0 ? 8'h41 : 8'h61) + 8'(k);
          drive(x, 2'(s));
          y = bus.out;
          compared++;
          if (y == x || y < (cs == 0 ? 8'h41 : 8'h61) || y > (cs == 0 ? 8'h5A : 8'h7A)) begin
            mismatched++;
            $display("FAIL inv_partner s=%0d got=%h input=%h expected=other letter same case", s, y, x);
          end
          drive(y, 2'(s));
          check("inv_roundtrip", bus.out, x);
        end
      end
    end

    drive(8'h72, 2'd3);
    check("lower_r_s3", bus.out, 8'h68);
    drive(8'h68, 2'd2);
    check("lower_h_s2", bus.out, 8'h63);

    for (int unsigned i = 0; i < 6; i++) begin
      drive(pass[i], 2'(i % 4));
      check("passthru", bus.out, pass[i]);
    end

    drive(8'h4C, 2'd0);
    check("L_s0", bus.out, 8'h59);
    drive(8'h4C, 2'd3);
    check("L_s3", bus.out, 8'h51);

    drive(8'h41, 2'd0);
    check("A_s0", bus.out, 8'h4F);
    @(negedge clk);
    bus.in = 8'h42;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_async", bus.out, 8'h00);
    @(posedge clk);
    #1 check("rst_mid_discard", bus.out, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_resume", bus.out, 8'h43);

    drive(8'h5A, 2'd0);
    check("Z_s0", bus.out, 8'h58);
    drive(8'h7A, 2'd3);
    check("z_s3", bus.out, 8'h79);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
